eka_mc_ctrl: RTL and testbench

- Multi-cycle sequencing controller for the Eka core.
- Takes the decoder's control bits and the branch-compare result, and steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB.
- Drives req/ack handshakes to instruction and data memory and issues single-cycle load/write strobes to the IR, PC and register file.
- Keeps a retired-instruction counter and a data-bus timeout watchdog.

---
 rtl/eka_mc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_eka_mc_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eka_mc_ctrl.sv
// eka_mc_ctrl -- multi-cycle sequencing controller for the Eka core.
//
// Each instruction steps through FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// The controller runs the imem/dmem req/ack handshakes and issues one-cycle
// load strobes to the IR, PC and register file. It also counts retired
// instructions and runs a watchdog on data-bus accesses.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   halt_req              stop after the current instruction retires
//   dec_*                 decoder control bits, stable from DECODE until WB
//   branch_taken          branch comparator result, sampled in EXEC
//   imem_req / imem_ack   instruction fetch handshake
//   dmem_req / dmem_we / dmem_ack   data access handshake
//   ir_load, rf_write, pc_load, pc_sel_target   datapath strobes
//   halted                controller is idle in HALT
//   bus_error             sticky flag for a dmem timeout (cleared only by reset)
//   instret               retired-instruction count, wraps silently
module eka_mc_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             dec_write_en,
  input  logic             dec_mem_read_en,
  input  logic             dec_mem_write_en,
  input  logic             dec_branch_inst,
  input  logic             dec_jump_inst,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_load,
  output logic             rf_write,
  output logic             pc_load,
  output logic             pc_sel_target,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  state_e            state_q,   state_d;
  logic              take_q,    take_d;
  logic [TO_W-1:0]   to_cnt_q,  to_cnt_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              bus_err_q, bus_err_d;

  // Ungated decoded outputs; gated with reset below.
  logic imem_req_c, dmem_req_c, dmem_we_c;
  logic ir_load_c, rf_write_c, pc_load_c, pc_sel_c;

  // NOTE: reset is sampled on the clock edge (synchronous), so it lives
  // inside the clocked block and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      take_q    <= 1'b0;
      to_cnt_q  <= '0;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      state_q   <= state_d;
      take_q    <= take_d;
      to_cnt_q  <= to_cnt_d;
      instret_q <= instret_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    take_d     = take_q;
    to_cnt_d   = to_cnt_q;
    instret_d  = instret_q;
    bus_err_d  = bus_err_q;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    ir_load_c  = 1'b0;
    rf_write_c = 1'b0;
    pc_load_c  = 1'b0;
    pc_sel_c   = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        take_d  = dec_jump_inst | (dec_branch_inst & branch_taken);
        state_d = (dec_mem_read_en | dec_mem_write_en) ? S_MEM : S_WB;
      end

      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = dec_mem_write_en;
        // An ack on the last allowed cycle still wins over the timeout.
        if (dmem_ack) begin
          to_cnt_d = '0;
          state_d  = S_WB;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d  = '0;
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      S_WB: begin
        rf_write_c = dec_write_en;
        pc_load_c  = 1'b1;
        pc_sel_c   = take_q;
        instret_d  = instret_q + 1'b1;
        state_d    = halt_req ? S_HALT : S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        // A bus error parks the core here until reset.
        if (!halt_req && !bus_err_q) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // While reset is asserted no access or strobe may leak out, even though
  // the state register may still hold a pre-reset state in that cycle.
  assign imem_req      = imem_req_c & ~reset;
  assign dmem_req      = dmem_req_c & ~reset;
  assign dmem_we       = dmem_we_c  & ~reset;
  assign ir_load       = ir_load_c  & ~reset;
  assign rf_write      = rf_write_c & ~reset;
  assign pc_load       = pc_load_c  & ~reset;
  assign pc_sel_target = pc_sel_c   & ~reset;
  assign bus_error     = bus_err_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_eka_mc_ctrl.sv
// Directed testbench for eka_mc_ctrl. A narrow instret (4 bits) makes the
// counter wrap reachable in a few dozen instructions.
module tb_eka_mc_ctrl;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 4;

  logic clk = 1'b0;
  logic reset;
  logic halt_req;
  logic dec_write_en, dec_mem_read_en, dec_mem_write_en;
  logic dec_branch_inst, dec_jump_inst, branch_taken;
  logic imem_req, imem_ack;
  logic dmem_req, dmem_we, dmem_ack;
  logic ir_load, rf_write, pc_load, pc_sel_target;
  logic halted, bus_error;
  logic [CNT_W-1:0] instret;

  int checks = 0;
  int errors = 0;
  int n;

  eka_mc_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .halt_req         (halt_req),
    .dec_write_en     (dec_write_en),
    .dec_mem_read_en  (dec_mem_read_en),
    .dec_mem_write_en (dec_mem_write_en),
    .dec_branch_inst  (dec_branch_inst),
    .dec_jump_inst    (dec_jump_inst),
    .branch_taken     (branch_taken),
    .imem_req         (imem_req),
    .imem_ack         (imem_ack),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_ack         (dmem_ack),
    .ir_load          (ir_load),
    .rf_write         (rf_write),
    .pc_load          (pc_load),
    .pc_sel_target    (pc_sel_target),
    .halted           (halted),
    .bus_error        (bus_error),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs driven afterwards apply to the new state.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_dec(input logic we, input logic rd, input logic wr,
                         input logic br, input logic jmp, input logic tk);
    dec_write_en     = we;
    dec_mem_read_en  = rd;
    dec_mem_write_en = wr;
    dec_branch_inst  = br;
    dec_jump_inst    = jmp;
    branch_taken     = tk;
  endtask

  // Non-memory instruction with zero-wait fetch; entry and exit in FETCH.
  task automatic run_instr(input string tag, input logic exp_rf, input logic exp_tgt);
    imem_ack = 1'b1;
    #1;
    check({tag, " fetch ir_load"}, ir_load, 1);
    cyc();
    check({tag, " decode ir_load"}, ir_load, 0);
    check({tag, " decode imem_req"}, imem_req, 0);
    cyc();
    check({tag, " exec pc_load"}, pc_load, 0);
    check({tag, " exec dmem_req"}, dmem_req, 0);
    cyc();
    check({tag, " wb rf_write"}, rf_write, exp_rf);
    check({tag, " wb pc_load"}, pc_load, 1);
    check({tag, " wb pc_sel_target"}, pc_sel_target, exp_tgt);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset = 1'b1; halt_req = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0);

    // ---- Reset ----
    cyc(); cyc();
    check("rst imem_req", imem_req, 0);
    check("rst dmem_req", dmem_req, 0);
    check("rst instret", instret, 0);
    check("rst bus_error", bus_error, 0);
    check("rst halted", halted, 0);
    reset = 1'b0;
    #1;
    check("post-rst imem_req", imem_req, 1);
    cyc();
    check("fetch wait imem_req", imem_req, 1);
    check("fetch wait ir_load", ir_load, 0);

    // ---- ADDI stream ----
    set_dec(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      run_instr("addi", 1, 0);
      check("addi instret", instret, i);
    end

    // ---- Branches and jump ----
    set_dec(0, 0, 0, 1, 0, 1);
    run_instr("br taken", 0, 1);
    check("br taken instret", instret, 4);
    set_dec(0, 0, 0, 1, 0, 0);
    run_instr("br not taken", 0, 0);
    check("br nt instret", instret, 5);
    set_dec(1, 0, 0, 0, 1, 0);
    run_instr("jal", 1, 1);
    check("jal instret", instret, 6);

    // ---- Load with 3 wait cycles: MEM lasts 4 cycles ----
    set_dec(1, 1, 0, 0, 0, 0);
    imem_ack = 1'b1;
    #1;
    check("ld fetch ir_load", ir_load, 1);
    cyc(); cyc(); cyc();
    n = 0;
    while (dmem_req === 1'b1 && n < 20) begin
      check("ld dmem_we", dmem_we, 0);
      check("ld no imem_req in mem", imem_req, 0);
      n++;
      dmem_ack = (n == 4);
      cyc();
      dmem_ack = 1'b0;
      #1;
    end
    check("ld mem cycles", n, 4);
    check("ld wb rf_write", rf_write, 1);
    check("ld wb pc_load", pc_load, 1);
    check("ld wb pc_sel_target", pc_sel_target, 0);
    cyc();
    check("ld instret", instret, 7);
    check("ld back to fetch", imem_req, 1);

    // ---- Store with ack in the first MEM cycle ----
    set_dec(0, 0, 1, 0, 0, 0);
    cyc(); cyc(); cyc();
    check("st dmem_req", dmem_req, 1);
    check("st dmem_we", dmem_we, 1);
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    #1;
    check("st wb dmem_req", dmem_req, 0);
    check("st wb rf_write", rf_write, 0);
    check("st wb pc_load", pc_load, 1);
    cyc();
    check("st instret", instret, 8);

    // ---- Halt requested during EXEC, then resume ----
    set_dec(1, 0, 0, 0, 0, 0);
    cyc(); cyc();
    halt_req = 1'b1;
    cyc();
    check("halt wb pc_load", pc_load, 1);
    check("halt wb halted", halted, 0);
    cyc();
    check("halt halted", halted, 1);
    check("halt imem_req", imem_req, 0);
    check("halt instret", instret, 9);
    cyc();
    check("halt stays", halted, 1);
    halt_req = 1'b0;
    cyc();
    check("resume imem_req", imem_req, 1);
    check("resume halted", halted, 0);

    // ---- Store timeout: dmem_ack never arrives ----
    set_dec(0, 0, 1, 0, 0, 0);
    cyc(); cyc(); cyc();
    n = 0;
    while (dmem_req === 1'b1 && n < 40) begin
      if (n == 0) check("to dmem_we", dmem_we, 1);
      check("to pc_load in mem", pc_load, 0);
      n++;
      cyc();
    end
    check("to dmem_req cycles", n, TIMEOUT);
    check("to bus_error", bus_error, 1);
    check("to halted", halted, 1);
    check("to pc_load", pc_load, 0);
    check("to instret", instret, 9);
    cyc(); cyc(); cyc();
    check("to no resume halted", halted, 1);
    check("to no resume imem_req", imem_req, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("to rst bus_error", bus_error, 0);
    check("to rst instret", instret, 0);
    check("to rst halted", halted, 0);
    check("to rst imem_req", imem_req, 1);

    // ---- Reset in the middle of a fetch ----
    set_dec(1, 0, 0, 0, 0, 0);
    run_instr("pre-rst addi", 1, 0);
    check("pre-rst instret", instret, 1);
    imem_ack = 1'b0;
    cyc();
    check("mid-fetch imem_req", imem_req, 1);
    reset = 1'b1;
    imem_ack = 1'b1;
    #1;
    check("rst cycle imem_req", imem_req, 0);
    check("rst cycle ir_load", ir_load, 0);
    cyc();
    reset = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("refetch instret", instret, 0);
    check("refetch imem_req", imem_req, 1);
    check("refetch ir_load", ir_load, 0);

    // ---- instret wrap: 15 = 2^CNT_W-1, then one more gives 0 ----
    for (int i = 1; i <= 16; i++) begin
      run_instr("wrap addi", 1, 0);
      check("wrap instret", instret, i % 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
